muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit_pkg.sv | 25 ++
 rtl/muldiv_div.sv | 39 +++
 rtl/muldiv_unit.sv | 128 ++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared CPU definitions for the HI/LO multiply/divide unit:
// instruction encodings, sequencer states and default latencies.
package muldiv_unit_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;

    localparam logic [5:0] FUNC_MULT  = 6'b011000;
    localparam logic [5:0] FUNC_MULTU = 6'b011001;
    localparam logic [5:0] FUNC_DIV   = 6'b011010;
    localparam logic [5:0] FUNC_DIVU  = 6'b011011;
    localparam logic [5:0] FUNC_MTHI  = 6'b010001;
    localparam logic [5:0] FUNC_MTLO  = 6'b010011;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    localparam logic [31:0] DIV0_QUO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } md_state_t;

endpackage

// File: rtl/muldiv_div.sv
// Combinational signed/unsigned 32-bit divider. Divide by zero yields
// all-ones quotient and the dividend as remainder; remainder follows dividend sign.
module muldiv_div
    import muldiv_unit_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        is_signed,
    output logic [31:0] quo,
    output logic [31:0] rem
);

    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;

    always_comb begin
        a_neg  = is_signed & a[31];
        b_neg  = is_signed & b[31];
        a_mag  = a_neg ? -a : a;
        b_mag  = b_neg ? -b : b;
        // keeps the unused divide path well defined when b is zero
        b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag  = a_mag / b_safe;
        r_mag  = a_mag % b_safe;
        if (b == 32'd0) begin
            quo = DIV0_QUO;
            rem = a;
        end else begin
            quo = (a_neg ^ b_neg) ? -q_mag : q_mag;
            rem = a_neg ? -r_mag : r_mag;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// HI/LO multiply/divide unit with fixed-latency sequencing and mthi/mtlo writes.
// state   | meaning
// ST_IDLE | ready; accepts mult/div start and mthi/mtlo
// ST_MUL  | multiply in flight, counting down to the HI/LO write
// ST_DIV  | divide in flight, counting down to the HI/LO write
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] Instr_E,
    input  logic        En_E,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy
);

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    md_state_t        state;
    md_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic             op_signed;

    logic [5:0]  func;
    logic        is_special;
    logic        is_mult;
    logic        is_div;
    logic        is_mthi;
    logic        is_mtlo;
    logic        idle;
    logic        start;
    logic        busy_int;
    logic        res_wr;
    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        unused_instr;

    assign func         = Instr_E[5:0];
    assign is_special   = (Instr_E[31:26] == OP_SPECIAL);
    assign is_mult      = is_special && (func == FUNC_MULT || func == FUNC_MULTU);
    assign is_div       = is_special && (func == FUNC_DIV  || func == FUNC_DIVU);
    assign is_mthi      = is_special && (func == FUNC_MTHI);
    assign is_mtlo      = is_special && (func == FUNC_MTLO);
    assign idle         = (state == ST_IDLE);
    assign start        = En_E & (is_mult | is_div) & idle;
    assign unused_instr = ^Instr_E[25:6];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = is_mult ? ST_MUL : ST_DIV;
            ST_MUL,
            ST_DIV:  if (cnt <= CNT_W'(1)) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Result lands on the edge the counter reaches zero, so Busy spans N cycles
    always_comb begin
        busy_int = start | (state != ST_IDLE);
        res_wr   = (state != ST_IDLE) && (cnt <= CNT_W'(1));
    end

    assign Busy = busy_int & rst_n;

    assign a_ext = {{32{op_signed & op_a[31]}}, op_a};
    assign b_ext = {{32{op_signed & op_b[31]}}, op_b};
    assign prod  = a_ext * b_ext;

    muldiv_div u_div (
        .a         (op_a),
        .b         (op_b),
        .is_signed (op_signed),
        .quo       (quo),
        .rem       (rem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_signed <= 1'b0;
            HI        <= '0;
            LO        <= '0;
        end else begin
            if (start) begin
                cnt       <= is_mult ? CNT_W'(MULT_CYCLES - 1) : CNT_W'(DIV_CYCLES - 1);
                op_a      <= A;
                op_b      <= B;
                op_signed <= (func == FUNC_MULT) || (func == FUNC_DIV);
            end else if (state != ST_IDLE && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (res_wr) begin
                if (state == ST_MUL) begin
                    HI <= prod[63:32];
                    LO <= prod[31:0];
                end else begin
                    HI <= rem;
                    LO <= quo;
                end
            end else if (En_E && idle) begin
                if (is_mthi) HI <= A;
                if (is_mtlo) LO <= A;
            end
        end
    end

endmodule
